cordic_sched: RTL and testbench
===============================

CORDIC_SCHED -- requirements
Module: cordic_sched

Interface
Parameters:
REQ-001 DATA_W, default 16, width of the signed I/Q operands.
REQ-002 ANGLE_W, default 9, width of the CORDIC angle result.
REQ-003 TIMEOUT, default 64, maximum WAIT cycles before the block aborts a job.

Ports:
REQ-004 clk  in  1  single system clock; every register is clocked on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 req0 / req1  in  1  job request from requester 0 / 1; level signal, held high until that requester's ack.
REQ-007 x0, y0 / x1, y1  in  DATA_W signed  I/Q operands of each requester; must be stable while its req is high.
REQ-008 ack0 / ack1  out  1  one-cycle job-complete pulse to requester 0 / 1.
REQ-009 angle0 / angle1  out  ANGLE_W  result register per requester; updated only in the cycle its ack is high.
REQ-010 err0 / err1  out  1  timeout flag per requester; valid in the cycle its ack is high.
REQ-011 cx, cy  out  DATA_W signed  operands driven to the shared CORDIC vectoring engine.
REQ-012 cstart  out  1  one-cycle start pulse to the CORDIC engine.
REQ-013 cangle  in  ANGLE_W  CORDIC angle output.
REQ-014 cfinished  in  1  CORDIC completion pulse.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, LAUNCH, WAIT, DONE; exactly one job is in flight at any time.
REQ-017 IDLE, no req high: stay in IDLE; cstart=0, ack0=0, ack1=0.
REQ-018 IDLE, exactly one req high: grant that requester, latch its x/y into cx/cy, go to LAUNCH.
REQ-019 IDLE, both req high: grant the requester that was not granted last (round-robin); then update the last-grant register.
REQ-020 LAUNCH: cstart=1 for exactly this cycle; clear the timeout counter; go to WAIT. cfinished seen in LAUNCH is ignored.
REQ-021 WAIT, cfinished=1: capture cangle into a result register; err=0; go to DONE.
REQ-022 WAIT, cfinished=0: increment the timeout counter; when the counter reaches TIMEOUT-1, go to DONE with err=1 and the result register unchanged.
REQ-023 WAIT, cfinished=1 in the same cycle as the timeout: completion wins; err=0.
REQ-024 DONE: for the granted requester only, pulse ack=1, load angleN from the result register, drive errN; return to IDLE the next cycle.
REQ-025 req is not sampled in DONE; a requester drops req on the edge ending its ack cycle, so IDLE never re-grants the same job.
REQ-026 cx/cy stay constant from LAUNCH through DONE, regardless of changes on x/y.
REQ-027 angleN and errN of a non-granted requester hold their previous values.
REQ-028 Latency: req first seen in IDLE at cycle t gives cstart at t+1; cfinished at cycle w≥t+2 gives ack at w+1.
REQ-029 The timeout counter is ceil(log2(TIMEOUT))+1 bits wide and saturates, never wraps; the back-to-back minimum period is 4 cycles (IDLE, LAUNCH, WAIT, DONE).

Reset
REQ-030 When rst=1 at a rising edge: state=IDLE; cstart, ack0, ack1, err0, err1, busy = 0; cx, cy, angle0, angle1 = 0; timeout counter = 0; last-grant = requester 1, so requester 0 wins the first tie.
REQ-031 Reset during LAUNCH, WAIT or DONE aborts the job with no ack; a cfinished arriving after reset is ignored in IDLE.

Verification
REQ-032 After reset, req0=1, x0=100, y0=100; cfinished with cangle=45 arrives 20 cycles after cstart -> one cstart, then ack0=1 one cycle after cfinished, angle0=45, err0=0, ack1 never high.
REQ-033 req0 and req1 high together from reset; every job completes -> grants alternate 0,1,0,1 across 4 jobs; cx/cy match the granted requester's operands each time.
REQ-034 req1=1 and the CORDIC never asserts cfinished -> ack1 with err1=1 exactly TIMEOUT+1 cycles after cstart (default TIMEOUT=64: 65 cycles); angle1 unchanged; block then returns to IDLE.
REQ-035 cfinished pulsed during LAUNCH and again 5 cycles later with cangle=300 -> the first pulse is ignored; ack returns angle=300.
REQ-036 rst asserted in WAIT -> no ack; all outputs zero the next cycle; a late cfinished causes no ack; the next req0 is served normally.
REQ-037 x0 changed while job 0 is in WAIT -> cx unchanged until DONE.

Source files
------------

// File: rtl/cordic_sched.sv
// cordic_sched: shares one CORDIC vectoring engine between two requesters.
// Round-robin on ties, one job in flight, and a saturating WAIT timeout.
module cordic_sched #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned ANGLE_W = 9,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req0,
   input  logic                     req1,
   input  logic signed [DATA_W-1:0] x0,
   input  logic signed [DATA_W-1:0] y0,
   input  logic signed [DATA_W-1:0] x1,
   input  logic signed [DATA_W-1:0] y1,
   output logic                     ack0,
   output logic                     ack1,
   output logic [ANGLE_W-1:0]       angle0,
   output logic [ANGLE_W-1:0]       angle1,
   output logic                     err0,
   output logic                     err1,
   output logic signed [DATA_W-1:0] cx,
   output logic signed [DATA_W-1:0] cy,
   output logic                     cstart,
   input  logic [ANGLE_W-1:0]       cangle,
   input  logic                     cfinished,
   output logic                     busy
);

   localparam int unsigned      CNT_W    = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_WAIT   = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t                     state_q;
   logic                       grant_q;
   logic                       last_q;
   logic [CNT_W-1:0]           cnt_q;
   logic [CNT_W-1:0]           cnt_d;
   logic                       pick_d;
   logic                       any_req_d;
   logic                       expired_d;
   logic                       ack0_q;
   logic                       ack1_q;
   logic                       err0_q;
   logic                       err1_q;
   logic                       cstart_q;
   logic                       busy_q;
   logic [ANGLE_W-1:0]         angle0_q;
   logic [ANGLE_W-1:0]         angle1_q;
   logic signed [DATA_W-1:0]   cx_q;
   logic signed [DATA_W-1:0]   cy_q;

   // Grant choice (tie goes to the requester not served last), saturating count, expiry
   always_comb begin
      any_req_d = req0 | req1;
      pick_d    = req1 & (~req0 | ~last_q);
      cnt_d     = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
      expired_d = (cnt_q >= CNT_LAST);
   end

   // Scheduler FSM with all outputs registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         grant_q  <= 1'b0;
         last_q   <= 1'b1;
         cnt_q    <= '0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         err0_q   <= 1'b0;
         err1_q   <= 1'b0;
         cstart_q <= 1'b0;
         busy_q   <= 1'b0;
         angle0_q <= '0;
         angle1_q <= '0;
         cx_q     <= '0;
         cy_q     <= '0;
      end else begin
         cstart_q <= 1'b0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (any_req_d) begin
                  grant_q  <= pick_d;
                  last_q   <= pick_d;
                  cx_q     <= pick_d ? x1 : x0;
                  cy_q     <= pick_d ? y1 : y0;
                  cstart_q <= 1'b1;
                  busy_q   <= 1'b1;
                  state_q  <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               cnt_q   <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (cfinished) begin
                  // Completion wins over a coincident timeout
                  if (grant_q) begin
                     ack1_q   <= 1'b1;
                     err1_q   <= 1'b0;
                     angle1_q <= cangle;
                  end else begin
                     ack0_q   <= 1'b1;
                     err0_q   <= 1'b0;
                     angle0_q <= cangle;
                  end
                  state_q <= S_DONE;
               end else if (expired_d) begin
                  // Abort: flag error, keep the previous angle
                  if (grant_q) begin
                     ack1_q <= 1'b1;
                     err1_q <= 1'b1;
                  end else begin
                     ack0_q <= 1'b1;
                     err0_q <= 1'b1;
                  end
                  state_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign ack0   = ack0_q;
   assign ack1   = ack1_q;
   assign err0   = err0_q;
   assign err1   = err1_q;
   assign angle0 = angle0_q;
   assign angle1 = angle1_q;
   assign cx     = cx_q;
   assign cy     = cy_q;
   assign cstart = cstart_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_cordic_sched.sv
// tb_cordic_sched: table of directed jobs, reset corner cases, then random jobs
// checked against a round-robin / deadline reference model.
module tb_cordic_sched;

   localparam int unsigned DATA_W  = 16;
   localparam int unsigned ANGLE_W = 9;
   localparam int          TMO     = 64;
   localparam int          NEVER   = -1;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     req0;
   logic                     req1;
   logic signed [DATA_W-1:0] x0;
   logic signed [DATA_W-1:0] y0;
   logic signed [DATA_W-1:0] x1;
   logic signed [DATA_W-1:0] y1;
   logic                     ack0;
   logic                     ack1;
   logic [ANGLE_W-1:0]       angle0;
   logic [ANGLE_W-1:0]       angle1;
   logic                     err0;
   logic                     err1;
   logic signed [DATA_W-1:0] cx;
   logic signed [DATA_W-1:0] cy;
   logic                     cstart;
   logic [ANGLE_W-1:0]       cangle;
   logic                     cfinished;
   logic                     busy;

   int total = 0;
   int bad   = 0;

   // Reference model state
   bit                 last_m;
   logic [ANGLE_W-1:0] m_angle [2];
   bit                 m_err   [2];

   typedef struct {
      bit                       rst_first;
      bit                       r0;
      bit                       r1;
      logic signed [DATA_W-1:0] ax0;
      logic signed [DATA_W-1:0] ay0;
      logic signed [DATA_W-1:0] ax1;
      logic signed [DATA_W-1:0] ay1;
      int                       d;
      bit                       spur;
      logic [ANGLE_W-1:0]       ang;
      bit                       eg;
      bit                       eerr;
      logic [ANGLE_W-1:0]       eang;
      int                       elat;
      logic signed [DATA_W-1:0] ecx;
      logic signed [DATA_W-1:0] ecy;
   } vec_t;

   vec_t tbl [12];

   always #5 clk = ~clk;

   cordic_sched #(
      .DATA_W (DATA_W),
      .ANGLE_W(ANGLE_W),
      .TIMEOUT(TMO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req0     (req0),
      .req1     (req1),
      .x0       (x0),
      .y0       (y0),
      .x1       (x1),
      .y1       (y1),
      .ack0     (ack0),
      .ack1     (ack1),
      .angle0   (angle0),
      .angle1   (angle1),
      .err0     (err0),
      .err1     (err1),
      .cx       (cx),
      .cy       (cy),
      .cstart   (cstart),
      .cangle   (cangle),
      .cfinished(cfinished),
      .busy     (busy)
   );

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset(input string tag);
      rst       = 1'b1;
      req0      = 1'b0;
      req1      = 1'b0;
      cfinished = 1'b0;
      tick();
      rst = 1'b0;
      check({tag, "_flags"}, {cstart, ack0, ack1, err0, err1, busy}, 0);
      check({tag, "_cx"}, cx, 0);
      check({tag, "_cy"}, cy, 0);
      check({tag, "_angle0"}, angle0, 0);
      check({tag, "_angle1"}, angle1, 0);
      last_m     = 1'b1;
      m_angle[0] = '0;
      m_angle[1] = '0;
      m_err[0]   = 1'b0;
      m_err[1]   = 1'b0;
   endtask

   // One job: called in an IDLE cycle, returns in the following IDLE cycle
   task automatic run_job(input bit r0, input bit r1,
                          input logic signed [DATA_W-1:0] ax0, input logic signed [DATA_W-1:0] ay0,
                          input logic signed [DATA_W-1:0] ax1, input logic signed [DATA_W-1:0] ay1,
                          input int d, input bit spur, input logic [ANGLE_W-1:0] ang,
                          input bit eg, input bit eerr, input logic [ANGLE_W-1:0] eang,
                          input int elat,
                          input logic signed [DATA_W-1:0] ecx, input logic signed [DATA_W-1:0] ecy);
      int k;
      int extra;
      bit seen;
      if (r0 && !req0) begin x0 = ax0; y0 = ay0; end
      if (r1 && !req1) begin x1 = ax1; y1 = ay1; end
      req0 = req0 | r0;
      req1 = req1 | r1;
      tick();
      check("cstart_latency", cstart, 1);
      check("busy_launch", busy, 1);
      check("cx_launch", cx, ecx);
      check("cy_launch", cy, ecy);
      if (spur) begin
         cfinished = 1'b1;
         cangle    = ~ang;
      end
      k     = 0;
      extra = 0;
      seen  = 1'b0;
      while (!seen && k <= TMO + 4) begin
         tick();
         k++;
         cfinished = 1'b0;
         if (ack0 || ack1) begin
            seen = 1'b1;
         end else begin
            if (cstart) extra++;
            if (k == 2) begin
               if (eg) begin x1 = ~x1; y1 = ~y1; end
               else    begin x0 = ~x0; y0 = ~y0; end
            end
            if (k == d) begin
               cfinished = 1'b1;
               cangle    = ang;
            end
         end
      end
      check("ack_seen", seen, 1);
      check("ack_latency", k, elat);
      check("ack_granted", eg ? ack1 : ack0, 1);
      check("ack_other", eg ? ack0 : ack1, 0);
      check("err_granted", eg ? err1 : err0, eerr);
      check("angle_granted", eg ? angle1 : angle0, eang);
      check("angle_other", eg ? angle0 : angle1, m_angle[!eg]);
      check("err_other", eg ? err0 : err1, m_err[!eg]);
      check("cx_hold", cx, ecx);
      check("cy_hold", cy, ecy);
      check("single_cstart", extra, 0);
      m_angle[eg] = eang;
      m_err[eg]   = eerr;
      last_m      = eg;
      if (eg) req1 = 1'b0;
      else    req0 = 1'b0;
      tick();
      check("busy_idle", busy, 0);
      check("ack_idle", {ack0, ack1}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit                       rr0;
      bit                       rr1;
      bit                       a0;
      bit                       a1;
      bit                       g;
      bit                       succ;
      int                       d;
      int                       sel;
      logic signed [DATA_W-1:0] nx0;
      logic signed [DATA_W-1:0] ny0;
      logic signed [DATA_W-1:0] nx1;
      logic signed [DATA_W-1:0] ny1;
      logic [ANGLE_W-1:0]       ang;

      rst       = 1'b1;
      req0      = 1'b0;
      req1      = 1'b0;
      x0        = '0;
      y0        = '0;
      x1        = '0;
      y1        = '0;
      cangle    = '0;
      cfinished = 1'b0;

      // rst_first r0 r1 ax0 ay0 ax1 ay1 d spur ang | eg eerr eang elat ecx ecy
      tbl[0]  = '{1, 1, 0, 100, 100, 0, 0, 20, 0, 45,       0, 0, 45, 21, 100, 100};
      tbl[1]  = '{0, 0, 1, 0, 0, -5, 7, 5, 1, 300,          1, 0, 300, 6, -5, 7};
      tbl[2]  = '{0, 0, 1, 0, 0, 3, -9, NEVER, 0, 0,        1, 1, 300, 65, 3, -9};
      tbl[3]  = '{0, 1, 0, 1000, -1000, 0, 0, 64, 0, 123,   0, 0, 123, 65, 1000, -1000};
      tbl[4]  = '{0, 1, 0, -32768, 32767, 0, 0, 65, 0, 10,  0, 1, 123, 65, -32768, 32767};
      tbl[5]  = '{0, 1, 1, 11, 12, 21, 22, 1, 0, 511,       1, 0, 511, 2, 21, 22};
      tbl[6]  = '{0, 1, 0, 11, 12, 0, 0, 3, 0, 0,           0, 0, 0, 4, 11, 12};
      tbl[7]  = '{1, 1, 1, 1, 2, 3, 4, 2, 0, 1,             0, 0, 1, 3, 1, 2};
      tbl[8]  = '{0, 1, 1, 5, 6, 3, 4, 7, 0, 2,             1, 0, 2, 8, 3, 4};
      tbl[9]  = '{0, 1, 1, 5, 6, 7, 8, 10, 0, 3,            0, 0, 3, 11, 5, 6};
      tbl[10] = '{0, 1, 1, 9, 10, 7, 8, 1, 0, 4,            1, 0, 4, 2, 7, 8};
      tbl[11] = '{0, 1, 0, 9, 10, 0, 0, NEVER, 0, 0,        0, 1, 3, 65, 9, 10};

      do_reset("reset");

      for (int i = 0; i < 12; i++) begin
         if (tbl[i].rst_first) do_reset("reset_tbl");
         run_job(tbl[i].r0, tbl[i].r1, tbl[i].ax0, tbl[i].ay0, tbl[i].ax1, tbl[i].ay1,
                 tbl[i].d, tbl[i].spur, tbl[i].ang, tbl[i].eg, tbl[i].eerr, tbl[i].eang,
                 tbl[i].elat, tbl[i].ecx, tbl[i].ecy);
      end

      // Reset in WAIT aborts the job; a late completion must be ignored
      x0   = 16'sd50;
      y0   = -16'sd60;
      req0 = 1'b1;
      tick();
      check("abort_cstart", cstart, 1);
      tick();
      tick();
      do_reset("abort");
      cfinished = 1'b1;
      cangle    = 9'd77;
      for (int i = 0; i < 4; i++) begin
         tick();
         cfinished = 1'b0;
         check("late_fin_quiet", {ack0, ack1, busy, cstart}, 0);
      end
      run_job(1, 0, 16'sd50, -16'sd60, 16'sd0, 16'sd0, 4, 0, 9'd200,
              0, 0, 9'd200, 5, 16'sd50, -16'sd60);

      // Random jobs against the reference model
      for (int i = 0; i < 40; i++) begin
         rr0 = 1'($urandom_range(0, 1));
         rr1 = 1'($urandom_range(0, 1));
         if (!(rr0 || rr1 || req0 || req1)) rr0 = 1'b1;
         nx0 = DATA_W'($urandom);
         ny0 = DATA_W'($urandom);
         nx1 = DATA_W'($urandom);
         ny1 = DATA_W'($urandom);
         ang = ANGLE_W'($urandom);
         sel = int'($urandom_range(0, 9));
         if (sel == 0)      d = NEVER;
         else if (sel == 1) d = TMO;
         else if (sel == 2) d = TMO + 1;
         else               d = int'($urandom_range(1, 30));
         a0   = req0 | rr0;
         a1   = req1 | rr1;
         g    = (a0 && a1) ? !last_m : a1;
         succ = (d >= 1) && (d <= TMO);
         run_job(rr0, rr1, nx0, ny0, nx1, ny1, d, 1'($urandom_range(0, 1)), ang,
                 g, !succ, succ ? ang : m_angle[g], succ ? d + 1 : TMO + 1,
                 g ? (req1 ? x1 : nx1) : (req0 ? x0 : nx0),
                 g ? (req1 ? y1 : ny1) : (req0 ? y0 : ny0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
